// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding load/store slave with
// fixed request-to-response latency and an internal word array.
module dmem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam int       DEPTH    = 1 << ADDR_W;
    localparam bit       LAT1     = (LATENCY == 1);
    localparam bit [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;

    logic [31:0] mem_q [DEPTH];

    logic              accept;
    logic              enter_resp;
    logic              c_we;
    logic [31:0]       c_addr;
    logic [31:0]       c_wdata;
    logic [3:0]        c_be;
    logic [ADDR_W-1:0] c_idx;
    logic              c_err;
    logic              commit_wr;

    assign req_ready  = !rst && (state_q == S_IDLE);
    assign accept     = req_valid && req_ready;
    assign enter_resp = !rst && ((accept && LAT1) ||
                        (state_q == S_WAIT && cnt_q == 4'd1));

    // With LATENCY==1 the commit edge is the accept edge, so use live inputs
    assign c_we    = (state_q == S_IDLE) ? req_we    : we_q;
    assign c_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
    assign c_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
    assign c_be    = (state_q == S_IDLE) ? req_be    : be_q;

    assign c_idx     = c_addr[ADDR_W+1:2];
    assign c_err     = (c_addr[1:0] != 2'b00) ||
                       (c_addr[31:ADDR_W+2] != '0);
    assign commit_wr = enter_resp && c_we && !c_err;

    always_ff @(posedge clk) begin
        if (commit_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (c_be[i]) begin
                    mem_q[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        be_q    <= req_be;
                        cnt_q   <= CNT_INIT;
                        state_q <= LAT1 ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state_q      <= S_IDLE;
                        resp_valid_q <= 1'b0;
                        resp_rdata_q <= '0;
                        resp_err_q   <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            if (enter_resp) begin
                resp_valid_q <= 1'b1;
                resp_err_q   <= c_err;
                resp_rdata_q <= (c_we || c_err) ? 32'd0 : mem_q[c_idx];
            end
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 instance for
// functional scenarios, LATENCY=1 instance for back-to-back throughput.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        req_valid_b = 1'b0;
    logic        req_ready_b;
    logic        req_we_b = 1'b0;
    logic [31:0] req_addr_b = '0;
    logic [31:0] req_wdata_b = '0;
    logic [3:0]  req_be_b = '0;
    logic        resp_valid_b;
    logic        resp_ready_b = 1'b1;
    logic [31:0] resp_rdata_b;
    logic        resp_err_b;

    int nvec = 0;
    int nerr = 0;

    dmem_responder #(.ADDR_W(10), .LATENCY(2)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_responder #(.ADDR_W(10), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_we(req_we_b), .req_addr(req_addr_b),
        .req_wdata(req_wdata_b), .req_be(req_be_b),
        .resp_valid(resp_valid_b), .resp_ready(resp_ready_b),
        .resp_rdata(resp_rdata_b), .resp_err(resp_err_b)
    );

    // Drives one transaction on the LATENCY=2 instance; starts and ends at a negedge.
    task automatic do_req(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          output int lat, output logic [31:0] rdata,
                          output logic err);
        int n;
        req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_we = ~we; req_addr = 32'hFFFF_FFFC; req_wdata = ~wdata; req_be = 4'hF;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!resp_valid) lat = -1;
        rdata = resp_rdata;
        err = resp_err;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        nvec++;
        if ({req_ready, resp_valid, resp_err} !== 3'b000 || resp_rdata !== 32'd0) begin
            nerr++;
            $display("FAIL reset_outputs got rdy=%b v=%b e=%b d=%h exp 0 0 0 0",
                     req_ready, resp_valid, resp_err, resp_rdata);
        end
        rst = 1'b0;
        #1;
        nvec++;
        if (req_ready !== 1'b1) begin
            nerr++;
            $display("FAIL reset_release_ready got %b exp 1", req_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_store_load();
        int lat; logic [31:0] rd; logic er;
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, er);
        nvec++;
        if (lat !== 2) begin nerr++; $display("FAIL t1_store_lat got %0d exp 2", lat); end
        nvec++;
        if ({rd, er} !== {32'd0, 1'b0}) begin
            nerr++; $display("FAIL t1_store_resp got %h/%b exp 00000000/0", rd, er);
        end
        do_req(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er);
        nvec++;
        if (lat !== 2) begin nerr++; $display("FAIL t1_load_lat got %0d exp 2", lat); end
        nvec++;
        if ({rd, er} !== {32'hDEADBEEF, 1'b0}) begin
            nerr++; $display("FAIL t1_load_resp got %h/%b exp deadbeef/0", rd, er);
        end
    endtask

    task automatic test_byte_mask();
        int lat; logic [31:0] rd; logic er;
        do_req(1'b1, 32'h20, 32'h11223344, 4'hF, lat, rd, er);
        do_req(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, lat, rd, er);
        do_req(1'b0, 32'h20, 32'h0, 4'h0, lat, rd, er);
        nvec++;
        if ({rd, er} !== {32'h11BB33DD, 1'b0}) begin
            nerr++; $display("FAIL t2_masked got %h/%b exp 11bb33dd/0", rd, er);
        end
        do_req(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, lat, rd, er);
        nvec++;
        if ({lat, rd, er} !== {32'd2, 32'd0, 1'b0}) begin
            nerr++; $display("FAIL t2_be0_resp got lat=%0d %h/%b exp 2 00000000/0", lat, rd, er);
        end
        do_req(1'b0, 32'h20, 32'h0, 4'h0, lat, rd, er);
        nvec++;
        if ({rd, er} !== {32'h11BB33DD, 1'b0}) begin
            nerr++; $display("FAIL t2_be0_noop got %h/%b exp 11bb33dd/0", rd, er);
        end
    endtask

    task automatic test_errors();
        int lat; logic [31:0] rd; logic er;
        do_req(1'b1, 32'h0, 32'h5A5A5A5A, 4'hF, lat, rd, er);
        do_req(1'b0, 32'h22, 32'h0, 4'h0, lat, rd, er);
        nvec++;
        if ({lat, rd, er} !== {32'd2, 32'd0, 1'b1}) begin
            nerr++; $display("FAIL t3_misaligned got lat=%0d %h/%b exp 2 00000000/1", lat, rd, er);
        end
        do_req(1'b1, 32'h1000, 32'h12345678, 4'hF, lat, rd, er);
        nvec++;
        if ({lat, rd, er} !== {32'd2, 32'd0, 1'b1}) begin
            nerr++; $display("FAIL t3_out_of_range got lat=%0d %h/%b exp 2 00000000/1", lat, rd, er);
        end
        do_req(1'b1, 32'h1, 32'hFFFFFFFF, 4'hF, lat, rd, er);
        nvec++;
        if (er !== 1'b1) begin nerr++; $display("FAIL t3_mis_store_err got %b exp 1", er); end
        do_req(1'b0, 32'h0, 32'h0, 4'h0, lat, rd, er);
        nvec++;
        if ({rd, er} !== {32'h5A5A5A5A, 1'b0}) begin
            nerr++; $display("FAIL t3_word0_intact got %h/%b exp 5a5a5a5a/0", rd, er);
        end
    endtask

    task automatic test_backpressure();
        int lat; logic [31:0] rd; logic er;
        req_we = 1'b0; req_addr = 32'h10; req_be = 4'h0; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b1; req_wdata = 32'h0; req_be = 4'hF;
        @(negedge clk);
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            nvec++;
            if ({resp_valid, resp_err, req_ready} !== 3'b100 || resp_rdata !== 32'hDEADBEEF) begin
                nerr++;
                $display("FAIL t4_hold_c%0d got v=%b e=%b rdy=%b d=%h exp 1 0 0 deadbeef",
                         i, resp_valid, resp_err, req_ready, resp_rdata);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        nvec++;
        if ({resp_valid, resp_err, req_ready} !== 3'b001 || resp_rdata !== 32'd0) begin
            nerr++;
            $display("FAIL t4_after_hs got v=%b e=%b rdy=%b d=%h exp 0 0 1 00000000",
                     resp_valid, resp_err, req_ready, resp_rdata);
        end
        do_req(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er);
        nvec++;
        if ({rd, er} !== {32'hDEADBEEF, 1'b0}) begin
            nerr++; $display("FAIL t4_no_late_store got %h/%b exp deadbeef/0", rd, er);
        end
    endtask

    task automatic test_reset_abort();
        int lat; logic [31:0] rd; logic er;
        do_req(1'b1, 32'h30, 32'h01020304, 4'hF, lat, rd, er);
        req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'hFFFFFFFF; req_be = 4'hF;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        nvec++;
        if ({req_ready, resp_valid} !== 2'b00) begin
            nerr++; $display("FAIL t5_rst_cycle got rdy=%b v=%b exp 0 0", req_ready, resp_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        nvec++;
        if (resp_valid !== 1'b0) begin
            nerr++; $display("FAIL t5_no_resp got v=%b exp 0", resp_valid);
        end
        do_req(1'b0, 32'h30, 32'h0, 4'h0, lat, rd, er);
        nvec++;
        if ({rd, er} !== {32'h01020304, 1'b0}) begin
            nerr++; $display("FAIL t5_store_aborted got %h/%b exp 01020304/0", rd, er);
        end
        req_we = 1'b1; req_addr = 32'h34; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        nvec++;
        if (resp_valid !== 1'b1) begin
            nerr++; $display("FAIL t5_resp_reached got v=%b exp 1", resp_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        nvec++;
        if (resp_valid !== 1'b0) begin
            nerr++; $display("FAIL t5_resp_dropped got v=%b exp 0", resp_valid);
        end
        rst = 1'b0;
        @(negedge clk);
        do_req(1'b0, 32'h34, 32'h0, 4'h0, lat, rd, er);
        nvec++;
        if ({rd, er} !== {32'hCAFEF00D, 1'b0}) begin
            nerr++; $display("FAIL t5_committed_kept got %h/%b exp cafef00d/0", rd, er);
        end
    endtask

    task automatic test_back_to_back();
        localparam int N = 6;
        logic        p_we   [N] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [31:0] p_addr [N] = '{32'h40, 32'h44, 32'h40, 32'h44, 32'h41, 32'h40};
        logic [31:0] p_data [N] = '{32'h0BADF00D, 32'h600DCAFE, 0, 0, 0, 0};
        logic [31:0] e_rd   [N] = '{32'd0, 32'd0, 32'h0BADF00D, 32'h600DCAFE, 32'd0, 32'h0BADF00D};
        logic        e_er   [N] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int acc [N];
        int ia = 0;
        int ir = 0;
        for (int cyc = 0; cyc < 40 && ir < N; cyc++) begin
            if (resp_valid_b) begin
                nvec++;
                if (ir >= ia || cyc !== acc[ir] + 1) begin
                    nerr++; $display("FAIL t6_lat_r%0d got cyc %0d exp %0d", ir, cyc, acc[ir] + 1);
                end
                nvec++;
                if ({resp_rdata_b, resp_err_b} !== {e_rd[ir], e_er[ir]}) begin
                    nerr++;
                    $display("FAIL t6_data_r%0d got %h/%b exp %h/%b",
                             ir, resp_rdata_b, resp_err_b, e_rd[ir], e_er[ir]);
                end
                if (ir > 0) begin
                    nvec++;
                    if (acc[ir] - acc[ir-1] !== 2) begin
                        nerr++;
                        $display("FAIL t6_spacing_r%0d got %0d exp 2", ir, acc[ir] - acc[ir-1]);
                    end
                end
                ir++;
            end
            if (ia < N) begin
                req_valid_b = 1'b1;
                req_we_b    = p_we[ia];
                req_addr_b  = p_addr[ia];
                req_wdata_b = p_data[ia];
                req_be_b    = 4'hF;
                if (req_ready_b) begin
                    acc[ia] = cyc;
                    ia++;
                end
            end else begin
                req_valid_b = 1'b0;
            end
            @(negedge clk);
        end
        req_valid_b = 1'b0;
        nvec++;
        if (ir !== N) begin
            nerr++; $display("FAIL t6_resp_count got %0d exp %0d", ir, N);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_mask();
        test_errors();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
